path_payoff_acc: RTL and testbench

Consumer end of the Monte Carlo price-path stream. Takes one 12-bit price sample per valid cycle and counts DAYS samples per path. At each terminal sample it computes the European call or put payoff against a latched strike and adds it to an accumulator. After 2^LOG2_PATHS paths it outputs the mean payoff as the option price. It also asks the path generator to restart between paths.

---
 rtl/path_payoff_acc_if.sv | 27 ++
 rtl/path_payoff_acc.sv | 123 ++++++++++++
 tb/tb_path_payoff_acc.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/path_payoff_acc_if.sv
// Signal bundle between the price-path generator side and the payoff accumulator.
// There is no back-pressure: a sample with in_valid=1 is taken in its own cycle, or dropped when the accumulator is not counting.
interface path_payoff_acc_if #(
  parameter int LOG2_PATHS = 8
);
  logic                start;
  logic [11:0]         strike;
  logic                is_put;
  logic                in_valid;
  logic [11:0]         in_path;
  logic                gen_clear;
  logic                busy;
  logic                done;
  logic [11:0]         price;
  logic [LOG2_PATHS:0] paths_done;
  logic [1:0]          dbg_state;

  modport master (
    output start, strike, is_put, in_valid, in_path,
    input  gen_clear, busy, done, price, paths_done, dbg_state
  );

  modport slave (
    input  start, strike, is_put, in_valid, in_path,
    output gen_clear, busy, done, price, paths_done, dbg_state
  );
endinterface

// File: rtl/path_payoff_acc.sv
// Accumulates European call/put payoffs over 2^LOG2_PATHS Monte Carlo paths
// and reports the truncated mean as the option price.
module path_payoff_acc #(
  parameter int DAYS       = 16,
  parameter int LOG2_PATHS = 8,
  parameter int FLUSH_CYC  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  path_payoff_acc_if.slave  bus
);

  localparam int DW = (DAYS > 1) ? $clog2(DAYS) : 1;
  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam int AW = 12 + LOG2_PATHS;
  localparam int PW = LOG2_PATHS + 1;
  localparam logic [DW-1:0] DAY_LAST  = DW'(DAYS - 1);
  localparam logic [FW-1:0] FLUSH_END = FW'(FLUSH_CYC - 1);
  localparam logic [PW-1:0] PATH_LAST = PW'((2 ** LOG2_PATHS) - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t          state;
  logic [11:0]     strike_q;
  logic            is_put_q;
  logic [DW-1:0]   day_cnt;
  logic [FW-1:0]   flush_cnt;
  logic [AW-1:0]   acc;
  logic [11:0]     price_q;
  logic [PW-1:0]   paths_q;
  logic            gen_clear_q;
  logic            busy_q;
  logic            done_q;

  logic [11:0]     payoff;
  logic [AW-1:0]   acc_sum;

  // Payoff is clamped at zero, so equal price and strike pays nothing either way.
  always_comb begin
    payoff = '0;
    if (is_put_q) begin
      if (strike_q > bus.in_path) payoff = strike_q - bus.in_path;
    end else begin
      if (bus.in_path > strike_q) payoff = bus.in_path - strike_q;
    end
    acc_sum = acc + AW'(payoff);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      strike_q    <= '0;
      is_put_q    <= 1'b0;
      day_cnt     <= '0;
      flush_cnt   <= '0;
      acc         <= '0;
      price_q     <= '0;
      paths_q     <= '0;
      gen_clear_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      gen_clear_q <= 1'b0;
      done_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            strike_q    <= bus.strike;
            is_put_q    <= bus.is_put;
            day_cnt     <= '0;
            flush_cnt   <= '0;
            acc         <= '0;
            paths_q     <= '0;
            gen_clear_q <= 1'b1;
            busy_q      <= 1'b1;
            state       <= FLUSH;
          end
        end
        FLUSH: begin
          // Samples still draining out of the generator pipeline are dropped here.
          if (flush_cnt == FLUSH_END) begin
            flush_cnt <= '0;
            state     <= RUN;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        RUN: begin
          if (bus.in_valid) begin
            if (day_cnt == DAY_LAST) begin
              day_cnt <= '0;
              acc     <= acc_sum;
              paths_q <= paths_q + 1'b1;
              if (paths_q == PATH_LAST) begin
                price_q <= acc_sum[AW-1:LOG2_PATHS];
                done_q  <= 1'b1;
                state   <= DONE;
              end else begin
                gen_clear_q <= 1'b1;
                state       <= FLUSH;
              end
            end else begin
              day_cnt <= day_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gen_clear  = gen_clear_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.price      = price_q;
  assign bus.paths_done = paths_q;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_path_payoff_acc.sv
// Directed bench for path_payoff_acc: a path-level reference model checked
// every cycle, plus hand-computed prices for each scenario.
module tb_path_payoff_acc;

  localparam int DAYS       = 4;
  localparam int LOG2_PATHS = 2;
  localparam int FLUSH_CYC  = 3;
  localparam int NPATHS     = 1 << LOG2_PATHS;

  logic clk;
  logic rst_n;

  path_payoff_acc_if #(.LOG2_PATHS(LOG2_PATHS)) bus ();

  path_payoff_acc #(
    .DAYS(DAYS), .LOG2_PATHS(LOG2_PATHS), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard bookkeeping ----------------
  int compared   = 0;
  int mismatched = 0;
  int gen_cnt    = 0;
  int done_cnt   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Path-level view: wait out the flush window, count samples, settle a path
  // on its DAYS-th sample, average after NPATHS paths.
  typedef enum int {M_IDLE, M_FLUSH, M_RUN, M_DONE} mode_t;
  mode_t       m_mode  = M_IDLE;
  int          m_wait  = 0;
  int          m_day   = 0;
  int          m_sum   = 0;
  int          m_k     = 0;
  bit          m_put   = 0;
  logic        e_gen   = 0;
  logic        e_busy  = 0;
  logic        e_done  = 0;
  logic [11:0] e_price = 0;
  int          e_paths = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_wait = 0; m_day = 0; m_sum = 0; m_k = 0; m_put = 0;
      e_gen = 0; e_busy = 0; e_done = 0; e_price = 0; e_paths = 0;
    end else begin
      int p, pay;
      e_gen  = 0;
      e_done = 0;
      case (m_mode)
        M_IDLE: if (bus.start) begin
          m_k = int'(bus.strike); m_put = bus.is_put;
          m_day = 0; m_sum = 0; e_paths = 0;
          e_gen = 1; m_wait = FLUSH_CYC; m_mode = M_FLUSH;
        end
        M_FLUSH: begin
          m_wait--;
          if (m_wait == 0) m_mode = M_RUN;
        end
        M_RUN: if (bus.in_valid) begin
          m_day++;
          if (m_day == DAYS) begin
            p = int'(bus.in_path);
            pay = m_put ? ((m_k > p) ? m_k - p : 0) : ((p > m_k) ? p - m_k : 0);
            m_sum += pay;
            m_day = 0;
            e_paths++;
            if (e_paths == NPATHS) begin
              e_price = 12'(m_sum / NPATHS);
              e_done = 1;
              m_mode = M_DONE;
            end else begin
              e_gen = 1; m_wait = FLUSH_CYC; m_mode = M_FLUSH;
            end
          end
        end
        M_DONE: m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
      e_busy = (m_mode != M_IDLE);
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("gen_clear", int'(bus.gen_clear), int'(e_gen));
    chk("busy", int'(bus.busy), int'(e_busy));
    chk("done", int'(bus.done), int'(e_done));
    chk("price", int'(bus.price), int'(e_price));
    chk("paths_done", int'(bus.paths_done), e_paths);
    if (bus.gen_clear) gen_cnt++;
    if (bus.done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_case(input string nm, input logic put, input logic [11:0] k,
                          input logic [11:0] t0, input logic [11:0] t1,
                          input logic [11:0] t2, input logic [11:0] t3,
                          input bit fill, input bit gaps, input bit rnd,
                          input bit st_run, input bit st_done,
                          input logic [11:0] exp_price);
    logic [11:0] terms[4];
    terms = '{t0, t1, t2, t3};
    step();
    gen_cnt = 0; done_cnt = 0;
    bus.strike = k; bus.is_put = put; bus.start = 1'b1; bus.in_valid = 1'b0;
    step();
    bus.start = 1'b0;
    bus.strike = ~k; bus.is_put = ~put;
    chk({nm, "_start_clears_paths"}, int'(bus.paths_done), 0);
    chk({nm, "_start_gen_clear"}, int'(bus.gen_clear), 1);
    for (int p = 0; p < NPATHS; p++) begin
      for (int f = 0; f < FLUSH_CYC; f++) begin
        bus.in_valid = fill; bus.in_path = 12'hFFF;
        step();
      end
      for (int d = 0; d < DAYS; d++) begin
        if (gaps) begin
          int g;
          g = $urandom_range(0, 2);
          for (int i = 0; i < g; i++) begin
            bus.in_valid = 1'b0; bus.in_path = 12'($urandom_range(0, 4095));
            step();
          end
        end
        bus.in_valid = 1'b1;
        bus.in_path  = (d == DAYS - 1 || !rnd) ? terms[p] : 12'($urandom_range(0, 4095));
        bus.start    = st_run && (p == 1) && (d == 1);
        step();
        bus.start = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    bus.start = st_done;
    step();
    bus.start = 1'b0;
    repeat (3) step();
    chk({nm, "_price"}, int'(bus.price), int'(exp_price));
    chk({nm, "_paths_done"}, int'(bus.paths_done), NPATHS);
    chk({nm, "_gen_clear_pulses"}, gen_cnt, NPATHS);
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_idle_after"}, int'(bus.busy), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1;
    bus.start = 1'b0; bus.strike = '0; bus.is_put = 1'b0;
    bus.in_valid = 1'b0; bus.in_path = '0;
    #2 rst_n = 1'b0;
    step(); step();
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_price", int'(bus.price), 0);
    chk("reset_paths", int'(bus.paths_done), 0);
    rst_n = 1'b1;
    step();

    run_case("call_flat", 1'b0, 12'h640, 12'h6E0, 12'h6E0, 12'h6E0, 12'h6E0,
             0, 0, 0, 0, 0, 12'h0A0);
    run_case("put_mix", 1'b1, 12'h640, 12'h5A0, 12'h6E0, 12'h640, 12'h618,
             0, 0, 0, 0, 0, 12'h032);
    run_case("call_gaps", 1'b0, 12'h640, 12'h6E0, 12'h500, 12'h780, 12'h668,
             0, 1, 1, 0, 0, 12'h082);
    run_case("flush_fill", 1'b0, 12'h640, 12'h6E0, 12'h6E0, 12'h6E0, 12'h6E0,
             1, 0, 0, 0, 0, 12'h0A0);
    run_case("start_ignored", 1'b0, 12'h640, 12'h6E0, 12'h6E0, 12'h6E0, 12'h6E0,
             0, 0, 1, 1, 1, 12'h0A0);
    run_case("call_k0", 1'b0, 12'h000, 12'h010, 12'h020, 12'h030, 12'h040,
             0, 0, 1, 0, 0, 12'h028);

    // Reset in the middle of path 2, then a clean run must not inherit acc.
    step();
    bus.strike = 12'h640; bus.is_put = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < FLUSH_CYC + DAYS + FLUSH_CYC + 2; i++) begin
      bus.in_valid = (i >= FLUSH_CYC); bus.in_path = 12'h7FF;
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_busy", int'(bus.busy), 0);
    chk("midrun_reset_price", int'(bus.price), 0);
    chk("midrun_reset_paths", int'(bus.paths_done), 0);
    chk("midrun_reset_gen_clear", int'(bus.gen_clear), 0);
    chk("midrun_reset_done", int'(bus.done), 0);
    bus.in_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    run_case("after_reset", 1'b0, 12'h640, 12'h6E0, 12'h6E0, 12'h6E0, 12'h6E0,
             0, 0, 0, 0, 0, 12'h0A0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
